mdu_iterative: RTL



---
 rtl/mdu_pkg.sv | 19 +
 rtl/mdu_abs_neg.sv | 15 +
 rtl/mdu_iterative.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } mduOp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mduState_t;

endpackage

// File: rtl/mdu_abs_neg.sv
// Combinational two's-complement conditional negate (magnitude / sign fix).
module mdu_abs_neg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic [WIDTH-1:0] result_c
);

    // Negate when requested, otherwise pass through.
    always_comb begin
        result_c = neg ? (~value + WIDTH'(1)) : value;
    end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] aData,
    input  logic [WIDTH-1:0] bData,
    input  logic             hiWe,
    input  logic             loWe,
    input  logic [WIDTH-1:0] wData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned AW = 2 * WIDTH;

    mduState_t        state, stateNext;
    logic [CW-1:0]    count, countNext;
    // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
    logic [AW-1:0]    acc, accNext;
    // Multiplicand for multiply, divisor for divide (magnitudes for signed ops).
    logic [WIDTH-1:0] opnd, opndNext;
    logic             isDiv, isDivNext;
    logic             signA, signANext;
    logic             signB, signBNext;
    logic             busyNext, doneNext;
    logic [WIDTH-1:0] hiNext, loNext;

    mduOp_t opIn;
    logic   opSigned, opDiv;

    assign opIn     = mduOp_t'(op);
    assign opSigned = (opIn == OP_MULT) || (opIn == OP_DIV);
    assign opDiv    = (opIn == OP_DIVU) || (opIn == OP_DIV);

    logic [WIDTH-1:0] magA, magB, quotFix, remFix;
    logic [AW-1:0]    prodFix;

    mdu_abs_neg #(.WIDTH(WIDTH)) uAbsA (
        .value(aData), .neg(opSigned & aData[WIDTH-1]), .result_c(magA));
    mdu_abs_neg #(.WIDTH(WIDTH)) uAbsB (
        .value(bData), .neg(opSigned & bData[WIDTH-1]), .result_c(magB));
    mdu_abs_neg #(.WIDTH(AW)) uFixProd (
        .value(acc), .neg(signA ^ signB), .result_c(prodFix));
    mdu_abs_neg #(.WIDTH(WIDTH)) uFixQuot (
        .value(acc[WIDTH-1:0]), .neg(signA ^ signB), .result_c(quotFix));
    mdu_abs_neg #(.WIDTH(WIDTH)) uFixRem (
        .value(acc[AW-1:WIDTH]), .neg(signA), .result_c(remFix));

    logic [WIDTH:0] mulSum, divShift, divDiff;

    // One shift-add step and one restoring-divide trial subtraction.
    assign mulSum   = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign divShift = {acc[AW-1:WIDTH], acc[WIDTH-1]};
    assign divDiff  = divShift - {1'b0, opnd};

    // Next-state, datapath and output logic.
    always_comb begin
        stateNext = state;
        countNext = count;
        accNext   = acc;
        opndNext  = opnd;
        isDivNext = isDiv;
        signANext = signA;
        signBNext = signB;
        hiNext    = hi;
        loNext    = lo;
        doneNext  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = RUN;
                    countNext = '0;
                    isDivNext = opDiv;
                    signANext = opSigned & aData[WIDTH-1];
                    signBNext = opSigned & bData[WIDTH-1];
                    opndNext  = opDiv ? magB : magA;
                    accNext   = {{WIDTH{1'b0}}, (opDiv ? magA : magB)};
                end else begin
                    if (hiWe) hiNext = wData;
                    if (loWe) loNext = wData;
                end
            end
            RUN: begin
                countNext = count + CW'(1);
                if (isDiv) begin
                    accNext = divDiff[WIDTH]
                            ? {divShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                            : {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                end else begin
                    accNext = {mulSum, acc[WIDTH-1:1]};
                end
                if (count == CW'(WIDTH - 1)) stateNext = FIX;
            end
            FIX: begin
                stateNext = IDLE;
                doneNext  = 1'b1;
                if (isDiv) begin
                    // Zero divisor: quotient all ones, remainder restores to the raw dividend.
                    loNext = (opnd == '0) ? '1 : quotFix;
                    hiNext = remFix;
                end else begin
                    hiNext = prodFix[AW-1:WIDTH];
                    loNext = prodFix[WIDTH-1:0];
                end
            end
            default: stateNext = IDLE;
        endcase
        busyNext = (stateNext != IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            acc   <= '0;
            opnd  <= '0;
            isDiv <= 1'b0;
            signA <= 1'b0;
            signB <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= stateNext;
            count <= countNext;
            acc   <= accNext;
            opnd  <= opndNext;
            isDiv <= isDivNext;
            signA <= signANext;
            signB <= signBNext;
            busy  <= busyNext;
            done  <= doneNext;
            hi    <= hiNext;
            lo    <= loNext;
        end
    end

endmodule
